clap_sequencer: RTL and testbench

//  Converts a raw clap-detect level from the sound front end into "successive clap" counts.

---
 rtl/clap_seq_pkg.sv | 19 +
 rtl/cycle_timer.sv | 27 ++
 rtl/clap_sequencer.sv | 131 +++++++++++++
 tb/tb_clap_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/clap_seq_pkg.sv
// Shared types and default windows for the clap sequencer.
// The optional drop counter is enabled by the CLAP_SEQ_DROP_CNT_EN macro.
package clap_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFRACT = 2'd1,
        GAP     = 2'd2,
        EMIT    = 2'd3
    } state_t;

    localparam int DEF_SUC_CLAPS_WIDTH = 16;
    localparam int DEF_REFRACT_CYCLES  = 2_500_000;
    localparam int DEF_GAP_CYCLES      = 25_000_000;
    localparam int DEF_TIMER_WIDTH     = 25;
    localparam int DEF_MAX_CLAPS       = 15;
    localparam int DROP_CNT_WIDTH      = 8;

endpackage

// File: rtl/cycle_timer.sv
// Up-counter with synchronous clear/enable; flags when the count reaches the terminal value.
module cycle_timer #(
    parameter int TIMER_WIDTH = 25
) (
    input  logic                   clock,
    input  logic                   nreset,
    input  logic                   i_clear,
    input  logic                   i_enable,
    input  logic [TIMER_WIDTH-1:0] i_terminal,
    output logic                   o_done
);

    logic [TIMER_WIDTH-1:0] r_count;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = i_enable && (r_count == i_terminal);

endmodule

// File: rtl/clap_sequencer.sv
// Groups clap edges into bursts and emits the saturated burst count on a valid/ready stream.
// Optional drop counter for ignored edges is enabled by defining CLAP_SEQ_DROP_CNT_EN.
module clap_sequencer
    import clap_seq_pkg::*;
#(
    parameter int SUC_CLAPS_WIDTH = DEF_SUC_CLAPS_WIDTH,
    parameter int REFRACT_CYCLES  = DEF_REFRACT_CYCLES,
    parameter int GAP_CYCLES      = DEF_GAP_CYCLES,
    parameter int TIMER_WIDTH     = DEF_TIMER_WIDTH,
    parameter int MAX_CLAPS       = DEF_MAX_CLAPS
) (
    input  logic                       clock,
    input  logic                       nreset,
    input  logic                       clap_in,
    output logic [SUC_CLAPS_WIDTH-1:0] suc_claps_data,
    output logic                       suc_claps_valid,
    input  logic                       suc_claps_ready,
    output logic                       busy
`ifdef CLAP_SEQ_DROP_CNT_EN
    ,
    output logic [DROP_CNT_WIDTH-1:0]  drop_count
`endif
);

    // States: IDLE wait for first clap | REFRACT ignore bounce | GAP wait for next clap | EMIT hold count until taken
    localparam logic [TIMER_WIDTH-1:0]     REFRACT_TC = TIMER_WIDTH'(REFRACT_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0]     GAP_TC     = TIMER_WIDTH'(GAP_CYCLES - 1);
    localparam logic [SUC_CLAPS_WIDTH-1:0] MAX_CNT    = SUC_CLAPS_WIDTH'(MAX_CLAPS);

    state_t                     r_state;
    logic                       r_clap_q;
    logic [SUC_CLAPS_WIDTH-1:0] r_count;
    logic [SUC_CLAPS_WIDTH-1:0] r_data;
    logic                       r_valid;
    logic                       r_busy;

    logic                       w_edge;
    logic                       w_timer_en;
    logic                       w_timer_clr;
    logic                       w_timer_done;
    logic [TIMER_WIDTH-1:0]     w_terminal;
    logic [SUC_CLAPS_WIDTH-1:0] w_count_inc;

    assign w_edge      = clap_in & ~r_clap_q;
    assign w_timer_en  = (r_state == REFRACT) || (r_state == GAP);
    assign w_terminal  = (r_state == REFRACT) ? REFRACT_TC : GAP_TC;
    // Restart the window on every state change and on a counted clap in GAP.
    assign w_timer_clr = !w_timer_en || w_timer_done || ((r_state == GAP) && w_edge);
    assign w_count_inc = (r_count >= MAX_CNT) ? MAX_CNT : r_count + 1'b1;

    cycle_timer #(
        .TIMER_WIDTH (TIMER_WIDTH)
    ) u_timer (
        .clock      (clock),
        .nreset     (nreset),
        .i_clear    (w_timer_clr),
        .i_enable   (w_timer_en),
        .i_terminal (w_terminal),
        .o_done     (w_timer_done)
    );

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_state  <= IDLE;
            r_clap_q <= 1'b0;
            r_count  <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_clap_q <= clap_in;
            case (r_state)
                IDLE: begin
                    if (w_edge) begin
                        r_count <= SUC_CLAPS_WIDTH'(1);
                        r_state <= REFRACT;
                        r_busy  <= 1'b1;
                    end
                end
                REFRACT: begin
                    if (w_timer_done) begin
                        r_state <= GAP;
                    end
                end
                GAP: begin
                    if (w_edge) begin
                        r_count <= w_count_inc;
                        r_state <= REFRACT;
                    end else if (w_timer_done) begin
                        r_state <= EMIT;
                        r_valid <= 1'b1;
                        r_data  <= r_count;
                    end
                end
                EMIT: begin
                    if (suc_claps_ready) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_count <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef CLAP_SEQ_DROP_CNT_EN
    logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;
    logic                      w_drop;

    assign w_drop = w_edge && ((r_state == REFRACT) || (r_state == EMIT));

    always_ff @(posedge clock) begin
        if (!nreset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign drop_count = r_drop_cnt;
`endif

    assign suc_claps_data  = r_data;
    assign suc_claps_valid = r_valid;
    assign busy            = r_busy;

endmodule

// File: tb/tb_clap_sequencer.sv
// Directed bench for clap_sequencer with short windows (refract 4, gap 10, saturation 3).
module tb_clap_sequencer;

    localparam int W  = 4;
    localparam int R  = 4;
    localparam int G  = 10;
    localparam int M  = 3;
    localparam int TW = 8;

    logic         clock = 1'b0;
    logic         nreset = 1'b0;
    logic         clap_in = 1'b0;
    logic         suc_claps_ready = 1'b1;
    logic [W-1:0] suc_claps_data;
    logic         suc_claps_valid;
    logic         busy;
`ifdef CLAP_SEQ_DROP_CNT_EN
    logic [7:0]   drop_count;
`endif

    int checks = 0;
    int errors = 0;
    int exp_drop = 0;

    logic [63:0]  valid_tr;
    logic [63:0]  busy_tr;
    logic [W-1:0] data_tr [64];

    always #5 clock = ~clock;

    clap_sequencer #(
        .SUC_CLAPS_WIDTH (W),
        .REFRACT_CYCLES  (R),
        .GAP_CYCLES      (G),
        .TIMER_WIDTH     (TW),
        .MAX_CLAPS       (M)
    ) dut (
        .clock           (clock),
        .nreset          (nreset),
        .clap_in         (clap_in),
        .suc_claps_data  (suc_claps_data),
        .suc_claps_valid (suc_claps_valid),
        .suc_claps_ready (suc_claps_ready),
        .busy            (busy)
`ifdef CLAP_SEQ_DROP_CNT_EN
        ,
        .drop_count      (drop_count)
`endif
    );

    // Cycle k: inputs applied and outputs sampled 1 time unit after posedge k.
    task automatic run(input logic [63:0] clap, input logic [63:0] rdy,
                       input logic [63:0] rst, input int ncyc);
        valid_tr = '0;
        busy_tr  = '0;
        for (int k = 0; k < ncyc; k++) begin
            clap_in         = clap[k];
            suc_claps_ready = rdy[k];
            nreset          = ~rst[k];
            valid_tr[k]     = suc_claps_valid;
            busy_tr[k]      = busy;
            data_tr[k]      = suc_claps_data;
            @(posedge clock);
            #1;
        end
        clap_in         = 1'b0;
        suc_claps_ready = 1'b1;
        nreset          = 1'b1;
    endtask

    function automatic int first_one(input logic [63:0] v);
        for (int i = 0; i < 64; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_drop(input string name);
`ifdef CLAP_SEQ_DROP_CNT_EN
        checks++;
        if (drop_count !== 8'(exp_drop)) begin
            errors++;
            $display("FAIL %s: drop_count got %0d expected %0d", name, drop_count, exp_drop);
        end
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (suc_claps_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", suc_claps_valid); end
        checks++;
        if (suc_claps_data !== 4'd0) begin errors++; $display("FAIL rst_data: got %0d expected 0", suc_claps_data); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        exp_drop = 0;
        check_drop("rst_drop");
        nreset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_single();
        logic [63:0] c;
        c = '0; c[0] = 1'b1;
        run(c, '1, '0, 25);
        checks++;
        if (busy_tr[0] !== 1'b0) begin errors++; $display("FAIL t1_busy0: got %b expected 0", busy_tr[0]); end
        checks++;
        if (busy_tr[1] !== 1'b1) begin errors++; $display("FAIL t1_busy1: got %b expected 1", busy_tr[1]); end
        checks++;
        if (first_one(valid_tr) != 15) begin errors++; $display("FAIL t1_valid_cycle: got %0d expected 15", first_one(valid_tr)); end
        checks++;
        if ($countones(valid_tr) != 1) begin errors++; $display("FAIL t1_valid_len: got %0d expected 1", $countones(valid_tr)); end
        checks++;
        if (data_tr[15] !== 4'd1) begin errors++; $display("FAIL t1_data: got %0d expected 1", data_tr[15]); end
        checks++;
        if (busy_tr[16] !== 1'b0) begin errors++; $display("FAIL t1_idle16: busy got %b expected 0", busy_tr[16]); end
    endtask

    task automatic test_two_claps();
        logic [63:0] c;
        c = '0; c[0] = 1'b1; c[8] = 1'b1;
        run(c, '1, '0, 30);
        checks++;
        if (first_one(valid_tr) != 23) begin errors++; $display("FAIL t2_valid_cycle: got %0d expected 23", first_one(valid_tr)); end
        checks++;
        if ($countones(valid_tr) != 1) begin errors++; $display("FAIL t2_valid_len: got %0d expected 1", $countones(valid_tr)); end
        checks++;
        if (data_tr[23] !== 4'd2) begin errors++; $display("FAIL t2_data: got %0d expected 2", data_tr[23]); end
    endtask

    task automatic test_refract_drop();
        logic [63:0] c;
        c = '0; c[0] = 1'b1; c[2] = 1'b1;
        run(c, '1, '0, 25);
        checks++;
        if (first_one(valid_tr) != 15) begin errors++; $display("FAIL t3_valid_cycle: got %0d expected 15", first_one(valid_tr)); end
        checks++;
        if (data_tr[15] !== 4'd1) begin errors++; $display("FAIL t3_data: got %0d expected 1", data_tr[15]); end
        exp_drop = exp_drop + 1;
        check_drop("t3_drop");
    endtask

    task automatic test_saturate();
        logic [63:0] c;
        c = '0;
        for (int i = 0; i < 5; i++) c[i*6] = 1'b1;
        run(c, '1, '0, 45);
        checks++;
        if (first_one(valid_tr) != 39) begin errors++; $display("FAIL t4_valid_cycle: got %0d expected 39", first_one(valid_tr)); end
        checks++;
        if (data_tr[39] !== 4'd3) begin errors++; $display("FAIL t4_data: got %0d expected 3", data_tr[39]); end
        check_drop("t4_drop");
    endtask

    task automatic test_gap_expiry_edge();
        logic [63:0] c;
        c = '0; c[0] = 1'b1; c[14] = 1'b1;
        run(c, '1, '0, 35);
        checks++;
        if (first_one(valid_tr) != 29) begin errors++; $display("FAIL t4b_valid_cycle: got %0d expected 29", first_one(valid_tr)); end
        checks++;
        if ($countones(valid_tr) != 1) begin errors++; $display("FAIL t4b_valid_len: got %0d expected 1", $countones(valid_tr)); end
        checks++;
        if (data_tr[29] !== 4'd2) begin errors++; $display("FAIL t4b_data: got %0d expected 2", data_tr[29]); end
    endtask

    task automatic test_backpressure();
        logic [63:0] c;
        logic [63:0] r;
        logic        stable;
        c = '0; c[0] = 1'b1; c[17] = 1'b1;
        r = '1;
        for (int i = 15; i < 20; i++) r[i] = 1'b0;
        run(c, r, '0, 30);
        checks++;
        if (first_one(valid_tr) != 15) begin errors++; $display("FAIL t5_valid_cycle: got %0d expected 15", first_one(valid_tr)); end
        checks++;
        if (valid_tr[21:15] !== 7'b0111111) begin errors++; $display("FAIL t5_valid_hold: got %b expected 0111111", valid_tr[21:15]); end
        stable = 1'b1;
        for (int i = 15; i <= 20; i++) if (data_tr[i] !== 4'd1) stable = 1'b0;
        checks++;
        if (stable !== 1'b1) begin errors++; $display("FAIL t5_data_hold: got data[20]=%0d expected 1 throughout", data_tr[20]); end
        checks++;
        if (busy_tr[29:21] !== 9'd0) begin errors++; $display("FAIL t5_idle: busy got %b expected all 0", busy_tr[29:21]); end
        exp_drop = exp_drop + 1;
        check_drop("t5_drop");
    endtask

    task automatic test_mid_reset();
        logic [63:0] c;
        logic [63:0] rs;
        c = '0; c[0] = 1'b1;
        rs = '0; rs[7] = 1'b1;
        run(c, '1, rs, 30);
        checks++;
        if (valid_tr !== 64'd0) begin errors++; $display("FAIL t6_no_valid: got %0d valid cycles expected 0", $countones(valid_tr)); end
        checks++;
        if (busy_tr[29:8] !== 22'd0) begin errors++; $display("FAIL t6_busy: got %b expected all 0", busy_tr[29:8]); end
        checks++;
        if (data_tr[8] !== 4'd0) begin errors++; $display("FAIL t6_data_rst: got %0d expected 0", data_tr[8]); end
        exp_drop = 0;
        check_drop("t6_drop");
        run(c, '1, '0, 20);
        checks++;
        if (first_one(valid_tr) != 15) begin errors++; $display("FAIL t6_after_cycle: got %0d expected 15", first_one(valid_tr)); end
        checks++;
        if (data_tr[15] !== 4'd1) begin errors++; $display("FAIL t6_after_data: got %0d expected 1", data_tr[15]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_claps();
        test_refract_drop();
        test_saturate();
        test_gap_expiry_edge();
        test_backpressure();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
